// File: rtl/board_reset_conditioner_pkg.sv
// Shared definitions for board-level reset blocks: FSM state encodings and
// small elaboration-time helpers for sizing counters from physical times.
package board_reset_conditioner_pkg;

    typedef enum logic [1:0] {
        POR     = 2'd0,
        RUN     = 2'd1,
        HOLD    = 2'd2,
        STRETCH = 2'd3
    } brc_state_e;

    // Clock cycles covering a window given in microseconds.
    function automatic int unsigned cycles_from_us(input int unsigned clk_hz,
                                                   input int unsigned us);
        return (clk_hz / 1000000) * us;
    endfunction

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer on the raw button pin followed by a debouncer that
// only accepts a new level after DEBOUNCE_CYCLES consecutive disagreeing samples.
module button_debouncer
    import board_reset_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter bit          ACTIVE_HIGH     = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic button_pressed
);

    localparam int unsigned CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic        IDLE_LVL = ~ACTIVE_HIGH;   // pin level when released
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          pressed_q, pressed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sync_pressed;

    // Polarity-normalise so that 1 always means pressed downstream.
    assign sync_pressed   = sync2_q ^ IDLE_LVL;
    assign button_pressed = pressed_q;

    // Debounce: count consecutive mismatches, flip the level on the last one.
    always_comb begin
        pressed_d = pressed_q;
        cnt_d     = '0;
        if (sync_pressed != pressed_q) begin
            if (cnt_q == CNT_LAST) begin
                pressed_d = ~pressed_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer and debounce state; reset parks on the released level.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_q   <= IDLE_LVL;
            sync2_q   <= IDLE_LVL;
            pressed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync1_q   <= button_raw;
            sync2_q   <= sync1_q;
            pressed_q <= pressed_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/board_reset_conditioner.sv
// Turns the raw reset push-button into a clean active-high SoC reset:
// power-on hold, debounced press detection, and a post-release stretch.
module board_reset_conditioner
    import board_reset_conditioner_pkg::*;
#(
    parameter int unsigned CLOCK_FREQUENCY    = 27000000,
    parameter int unsigned DEBOUNCE_US        = 10000,
    parameter int unsigned POR_CYCLES         = 1024,
    parameter int unsigned STRETCH_CYCLES     = 256,
    parameter bit          BUTTON_ACTIVE_HIGH = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic button_raw,
    output logic soc_reset,
    output logic button_pressed,
    output logic reset_event
);

    localparam int unsigned DEBOUNCE_CYCLES = cycles_from_us(CLOCK_FREQUENCY, DEBOUNCE_US);
    localparam int unsigned CNT_N = (POR_CYCLES > STRETCH_CYCLES) ? POR_CYCLES : STRETCH_CYCLES;
    localparam int unsigned CW    = cnt_width(CNT_N);
    localparam logic [CW-1:0] POR_LAST     = CW'(POR_CYCLES - 1);
    localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);

    brc_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          soc_reset_q, soc_reset_d;
    logic          reset_event_q, reset_event_d;
    logic          pressed;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_HIGH     (BUTTON_ACTIVE_HIGH)
    ) u_debouncer (
        .clock          (clock),
        .reset          (reset),
        .button_raw     (button_raw),
        .button_pressed (pressed)
    );

    assign button_pressed = pressed;
    assign soc_reset      = soc_reset_q;
    assign reset_event    = reset_event_q;

    // Next state; soc_reset is derived from the next state so it moves on the
    // same edge as the state register. Counter clears on every transition.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        reset_event_d = 1'b0;
        case (state_q)
            POR: begin
                if (cnt_q == POR_LAST) begin
                    cnt_d   = '0;
                    state_d = pressed ? HOLD : RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (pressed) begin
                    state_d       = HOLD;
                    reset_event_d = 1'b1;
                end
            end
            HOLD: begin
                cnt_d = '0;
                if (!pressed) begin
                    state_d = STRETCH;
                end
            end
            STRETCH: begin
                // A re-press wins over the terminal count and emits no event.
                if (pressed) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end else if (cnt_q == STRETCH_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = POR;
                cnt_d   = '0;
            end
        endcase
        soc_reset_d = (state_d != RUN);
    end

    // State, counter and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= POR;
            cnt_q         <= '0;
            soc_reset_q   <= 1'b1;
            reset_event_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            soc_reset_q   <= soc_reset_d;
            reset_event_q <= reset_event_d;
        end
    end

endmodule

// File: tb/tb_board_reset_conditioner.sv
// Scoreboard bench: stimulus pushes the hand-computed cycle and value of every
// expected output change; a monitor pops one entry per observed change.
module tb_board_reset_conditioner;

    typedef struct {
        int         cyc;
        logic [2:0] v;      // {soc_reset, button_pressed, reset_event}
        string      name;
    } exp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;
    bit   done1 = 1'b0;

    logic rst0, raw0, soc0, bp0, ev0;
    logic rst1, raw1, soc1, bp1, ev1;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    board_reset_conditioner #(
        .CLOCK_FREQUENCY(1000000), .DEBOUNCE_US(4), .POR_CYCLES(8),
        .STRETCH_CYCLES(5), .BUTTON_ACTIVE_HIGH(1'b1)
    ) u_dut (
        .clock(clk), .reset(rst0), .button_raw(raw0),
        .soc_reset(soc0), .button_pressed(bp0), .reset_event(ev0)
    );

    board_reset_conditioner #(
        .CLOCK_FREQUENCY(1000000), .DEBOUNCE_US(4), .POR_CYCLES(8),
        .STRETCH_CYCLES(5), .BUTTON_ACTIVE_HIGH(1'b0)
    ) u_dut_n (
        .clock(clk), .reset(rst1), .button_raw(raw1),
        .soc_reset(soc1), .button_pressed(bp1), .reset_event(ev1)
    );

    function automatic void expect0(input int c, input logic [2:0] v, input string n);
        exp_t e;
        e.cyc = c; e.v = v; e.name = n;
        q0.push_back(e);
    endfunction

    function automatic void expect1(input int c, input logic [2:0] v, input string n);
        exp_t e;
        e.cyc = c; e.v = v; e.name = n;
        q1.push_back(e);
    endfunction

    // Return 1 ns after the posedge that brings the cycle count to c.
    task automatic at_cyc(input int c);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < c);
    endtask

    task automatic pop_check(input int idx, input logic [2:0] o);
        exp_t e;
        bit   have;
        have = 1'b0;
        if (idx == 0 && q0.size() > 0) begin
            e = q0.pop_front(); have = 1'b1;
        end else if (idx == 1 && q1.size() > 0) begin
            e = q1.pop_front(); have = 1'b1;
        end
        tests++;
        if (!have) begin
            failed++;
            $display("FAIL dut%0d unexpected_change: got cycle %0d soc/bp/ev=%b, required no change",
                     idx, cyc, o);
        end else if (e.cyc != cyc || e.v !== o) begin
            failed++;
            $display("FAIL dut%0d %s: got cycle %0d soc/bp/ev=%b, required cycle %0d soc/bp/ev=%b",
                     idx, e.name, cyc, o, e.cyc, e.v);
        end
    endtask

    // Monitor: any change on a DUT's outputs consumes one expected entry.
    initial begin
        logic [2:0] prev0, prev1, o0, o1;
        prev0 = 3'bxxx;
        prev1 = 3'bxxx;
        forever begin
            @(negedge clk);
            o0 = {soc0, bp0, ev0};
            o1 = {soc1, bp1, ev1};
            if (o0 !== prev0) begin
                pop_check(0, o0);
                prev0 = o0;
            end
            if (o1 !== prev1) begin
                pop_check(1, o1);
                prev1 = o1;
            end
        end
    end

    // Active-low button instance: idle high, press is a low level.
    initial begin
        rst1 = 1'b0; raw1 = 1'b1;
        expect1(1, 3'b100, "n_reset_state");
        at_cyc(3);  rst1 = 1'b1; expect1(11, 3'b000, "n_por_end");
        at_cyc(15); raw1 = 1'b0;
        expect1(21, 3'b010, "n_press_debounced");
        expect1(22, 3'b111, "n_hold_event");
        expect1(23, 3'b110, "n_event_end");
        at_cyc(25); raw1 = 1'b1;
        expect1(31, 3'b100, "n_release_debounced");
        expect1(37, 3'b000, "n_stretch_end");
        done1 = 1'b1;
    end

    // Active-high instance: main scenarios.
    initial begin
        rst0 = 1'b0; raw0 = 1'b0;
        expect0(1, 3'b100, "reset_state");
        at_cyc(3);  rst0 = 1'b1; expect0(11, 3'b000, "por_end");

        // Clean press held 20 cycles, then release and stretch.
        at_cyc(15); raw0 = 1'b1;
        expect0(21, 3'b010, "press_debounced");
        expect0(22, 3'b111, "hold_event");
        expect0(23, 3'b110, "event_end");
        at_cyc(35); raw0 = 1'b0;
        expect0(41, 3'b100, "release_debounced");
        expect0(47, 3'b000, "stretch_end");

        // 3-cycle glitches with 1-cycle gaps: nothing may change.
        for (int k = 0; k < 4; k++) begin
            at_cyc(50 + 4 * k); raw0 = 1'b1;
            at_cyc(53 + 4 * k); raw0 = 1'b0;
        end

        // Press, then re-press landing mid-stretch (counter 3).
        at_cyc(70); raw0 = 1'b1;
        expect0(76, 3'b010, "press2_debounced");
        expect0(77, 3'b111, "hold2_event");
        expect0(78, 3'b110, "event2_end");
        at_cyc(85); raw0 = 1'b0; expect0(91, 3'b100, "release2_debounced");
        at_cyc(89); raw0 = 1'b1; expect0(95, 3'b110, "repress_mid_stretch");
        // Re-press landing on the terminal stretch count must still win.
        at_cyc(100); raw0 = 1'b0; expect0(106, 3'b100, "release3_debounced");
        at_cyc(105); raw0 = 1'b1; expect0(111, 3'b110, "repress_terminal");
        at_cyc(115); raw0 = 1'b0;
        expect0(121, 3'b100, "release4_debounced");
        expect0(127, 3'b000, "full_stretch_end");

        // Reset while held in HOLD: POR restarts, exits to HOLD silently.
        at_cyc(130); raw0 = 1'b1;
        expect0(136, 3'b010, "press5_debounced");
        expect0(137, 3'b111, "hold5_event");
        expect0(138, 3'b110, "event5_end");
        at_cyc(140); rst0 = 1'b0; expect0(141, 3'b100, "mid_reset_state");
        at_cyc(141); rst0 = 1'b1; expect0(147, 3'b110, "por_press_debounced");
        at_cyc(155); raw0 = 1'b0;
        expect0(161, 3'b100, "release5_debounced");
        expect0(167, 3'b000, "stretch5_end");

        at_cyc(175);
        for (int t = 0; t < 100 && !done1; t++) @(posedge clk);

        tests++;
        if (q0.size() != 0) begin
            failed++;
            $display("FAIL dut0 missing_changes: got %0d pending, required 0 (next %s at cycle %0d)",
                     q0.size(), q0[0].name, q0[0].cyc);
        end
        tests++;
        if (q1.size() != 0 || !done1) begin
            failed++;
            $display("FAIL dut1 missing_changes: got %0d pending done=%0d, required 0 done=1",
                     q1.size(), done1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
